// File: rtl/eps_greedy_selector.sv
// Epsilon-greedy selector: serial signed argmax over NUM_ACTIONS lanes, LFSR-driven exploration.
// Latency: result valid NUM_ACTIONS+2 cycles after accept; one decision per NUM_ACTIONS+3 cycles.
// Backpressure: result held stable until out_ready, in_ready low while busy. Option: EPS_DECAY_EN.
module eps_greedy_selector #(
  parameter int                 NUM_ACTIONS = 4,
  parameter int                 Q_WIDTH     = 16,
  parameter int                 FRAC_BITS   = 8,
  parameter logic [15:0]        LFSR_SEED   = 16'hACE1,
  parameter int                 DECAY_SHIFT = 4,
  parameter logic [Q_WIDTH-1:0] EPS_MIN     = Q_WIDTH'(16'h0008),
  localparam int                IDX_W       = $clog2(NUM_ACTIONS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_ACTIONS*Q_WIDTH-1:0] q_values,
  input  logic [Q_WIDTH-1:0]             epsilon,
`ifdef EPS_DECAY_EN
  input  logic                           eps_load,
`endif
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_ACTIONS-1:0]         action,
  output logic [IDX_W-1:0]               action_idx,
  output logic                           explored
);

  typedef enum logic [1:0] {IDLE, SCAN, DECIDE, HOLD} state_t;

  localparam logic [15:0]      SEED      = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(NUM_ACTIONS - 1);

  state_t                         state, state_nxt;
  logic [NUM_ACTIONS*Q_WIDTH-1:0] q_reg;
  logic [IDX_W-1:0]               lane_cnt;
  logic [IDX_W-1:0]               best_idx;
  logic signed [Q_WIDTH-1:0]      best_val;
  logic signed [Q_WIDTH-1:0]      lane_val;
  logic [15:0]                    lfsr;
  logic [Q_WIDTH-1:0]             eps_cmp;
  logic [Q_WIDTH-1:0]             rand_frac;
  logic [IDX_W-1:0]               rand_idx;
  logic                           explore;
  logic [IDX_W-1:0]               result_idx;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SCAN;
      end
      SCAN:    if (lane_cnt == LAST_LANE) state_nxt = DECIDE;
      DECIDE:  state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    lane_val = '0;
    for (int i = 0; i < NUM_ACTIONS; i++) begin
      if (lane_cnt == IDX_W'(i)) lane_val = q_reg[i*Q_WIDTH +: Q_WIDTH];
    end
  end

  // Low LFSR bits form a fraction in [0,1) on the same scale as epsilon.
  always_comb begin
    rand_frac  = Q_WIDTH'(lfsr[FRAC_BITS-1:0]);
    rand_idx   = IDX_W'(lfsr[15:8] % 8'(NUM_ACTIONS));
    explore    = (rand_frac < eps_cmp);
    result_idx = explore ? rand_idx : best_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg      <= '0;
      lane_cnt   <= '0;
      best_idx   <= '0;
      best_val   <= '0;
      lfsr       <= SEED;
      out_valid  <= 1'b0;
      action     <= '0;
      action_idx <= '0;
      explored   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            q_reg    <= q_values;
            lane_cnt <= '0;
          end
        end
        SCAN: begin
          // Strict compare keeps the lowest index on ties.
          if (lane_cnt == '0 || lane_val > best_val) begin
            best_val <= lane_val;
            best_idx <= lane_cnt;
          end
          lane_cnt <= lane_cnt + IDX_W'(1);
        end
        DECIDE: begin
          lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
          out_valid  <= 1'b1;
          action_idx <= result_idx;
          action     <= NUM_ACTIONS'(1) << result_idx;
          explored   <= explore;
        end
        HOLD: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef EPS_DECAY_EN
  logic [Q_WIDTH-1:0] eps_reg;
  logic [Q_WIDTH-1:0] eps_dec;
  logic [Q_WIDTH-1:0] eps_decayed;

  always_comb begin
    eps_dec     = eps_reg - (eps_reg >> DECAY_SHIFT);
    eps_decayed = (eps_dec < EPS_MIN) ? EPS_MIN : eps_dec;
  end

  always_ff @(posedge clk) begin
    if (rst)                               eps_reg <= '0;
    else if (state == IDLE && eps_load)    eps_reg <= epsilon;
    else if (out_valid && out_ready)       eps_reg <= eps_decayed;
  end

  assign eps_cmp = eps_reg;
`else
  logic [Q_WIDTH-1:0] eps_lat;

  always_ff @(posedge clk) begin
    if (rst)                           eps_lat <= '0;
    else if (state == IDLE && in_valid) eps_lat <= epsilon;
  end

  assign eps_cmp = eps_lat;

  // Decay configuration only matters when the decay option is built in.
  logic unused_decay_cfg;
  assign unused_decay_cfg = ^{EPS_MIN, 32'(DECAY_SHIFT)};
`endif

endmodule

// File: tb/tb_eps_greedy_selector.sv
// Bench for eps_greedy_selector: table of Q-vectors through a scoreboard, plus
// hand-written backpressure and mid-scan reset sequences.
module tb_eps_greedy_selector;
  localparam int          N    = 4;
  localparam int          QW   = 16;
  localparam logic [15:0] SEED = 16'hACE1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [N*QW-1:0] q_values;
  logic [QW-1:0]   epsilon;
`ifdef EPS_DECAY_EN
  logic            eps_load;
`endif
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    action;
  logic [1:0]      action_idx;
  logic            explored;

  always #5 clk = ~clk;

  eps_greedy_selector #(.NUM_ACTIONS(N), .Q_WIDTH(QW), .FRAC_BITS(8), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .q_values(q_values), .epsilon(epsilon),
`ifdef EPS_DECAY_EN
    .eps_load(eps_load),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .action(action), .action_idx(action_idx), .explored(explored)
  );

  typedef struct packed {logic [1:0] idx; logic expl;} exp_t;
  typedef struct {logic [N*QW-1:0] q; logic [15:0] eps; int greedy;} vec_t;

  exp_t        sb[$];
  vec_t        vecs[9];
  logic [15:0] model_lfsr;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [N*QW-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [N*QW-1:0] v;
    v[15:0]  = 16'(a);
    v[31:16] = 16'(b);
    v[47:32] = 16'(c);
    v[63:48] = 16'(d);
    return v;
  endfunction

  // Expected result: explore when the random fraction is below epsilon.
  task automatic push_expect(input logic [15:0] eps, input int greedy);
    exp_t        e;
    logic [15:0] r;
    logic [7:0]  m;
    r      = {8'h00, model_lfsr[7:0]};
    m      = model_lfsr[15:8] % 8'd4;
    e.expl = (r < eps);
    e.idx  = e.expl ? m[1:0] : 2'(greedy);
    model_lfsr = lfsr_next(model_lfsr);
    sb.push_back(e);
  endtask

  task automatic drive(input logic [N*QW-1:0] q, input logic [15:0] eps, input int greedy);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    q_values = q;
    epsilon  = eps;
`ifdef EPS_DECAY_EN
    eps_load = 1'b1;
`endif
    push_expect(eps, greedy);
    @(posedge clk); #1;
    in_valid = 1'b0;
`ifdef EPS_DECAY_EN
    eps_load = 1'b0;
`endif
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_idx"}, 32'(action_idx), 32'(e.idx));
    check({tag, "_explored"}, 32'(explored), 32'(e.expl));
    check({tag, "_action"}, 32'(action), 32'(4'b0001 << e.idx));
  endtask

  task automatic run(input logic [N*QW-1:0] q, input logic [15:0] eps, input int greedy,
                     input string tag);
    int lat;
    drive(q, eps, greedy);
    wait_out(lat);
    check({tag, "_latency"}, 32'(lat), 32'd5);
    if (!out_valid) begin
      void'(sb.pop_front());
      return;
    end
    check_out(tag);
    @(posedge clk); #1;
    check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required to finish");
    $fatal(1);
  end

  initial begin
    int   lat;
    exp_t hold_e;

    vecs[0] = '{pack4(3*256, 2*256, 1*256, 12*256), 16'h0000, 3};
    vecs[1] = '{pack4(-5*256, 7*256, 7*256, -1*256), 16'h0000, 1};
    vecs[2] = '{pack4(4*256, 4*256, 4*256, 4*256), 16'h0000, 0};
    vecs[3] = '{pack4(-1*256, -2*256, -3*256, -4*256), 16'h0000, 0};
    vecs[4] = '{pack4(-32768, 32767, 0, 1), 16'h0000, 1};
    vecs[5] = '{pack4(1*256, 2*256, 3*256, 4*256), 16'h0100, 3};
    vecs[6] = '{pack4(0, 0, 0, 9*256), 16'h0080, 3};
    vecs[7] = '{pack4(5, 6, 7, 8), 16'hFFFF, 3};
    vecs[8] = '{pack4(0, 0, 256, 0), 16'h0000, 2};

    rst       = 1'b1;
    in_valid  = 1'b0;
    q_values  = '0;
    epsilon   = '0;
    out_ready = 1'b1;
`ifdef EPS_DECAY_EN
    eps_load  = 1'b0;
`endif
    model_lfsr = SEED;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_action", 32'(action), 32'd0);
    check("reset_action_idx", 32'(action_idx), 32'd0);
    check("reset_explored", 32'(explored), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Seed 16'hACE1 with epsilon 1.0 must explore to index 0xAC % 4 = 0.
    drive(pack4(1*256, 5*256, 2*256, 3*256), 16'h0100, 1);
    wait_out(lat);
    check("seed_explored", 32'(explored), 32'd1);
    check("seed_idx", 32'(action_idx), 32'd0);
    check("seed_action", 32'(action), 32'd1);
    check_out("seed");
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run(vecs[i].q, vecs[i].eps, vecs[i].greedy, $sformatf("vec%0d", i));
    end

    // Backpressure: result held, new input ignored.
    out_ready = 1'b0;
    drive(pack4(0, 0, 9*256, 0), 16'h0000, 2);
    wait_out(lat);
    check("bp_latency", 32'(lat), 32'd5);
    hold_e = (sb.size() != 0) ? sb[0] : '0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      q_values = pack4(100, 0, 0, 0);
      @(posedge clk); #1;
      check($sformatf("bp_hold_idx%0d", k), 32'(action_idx), 32'(hold_e.idx));
      check($sformatf("bp_hold_valid%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("bp_in_ready%0d", k), 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_out("bp");
    @(posedge clk); #1;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    check("bp_no_stray_result", 32'(out_valid), 32'd0);
    run(pack4(7, 3, 2, 1), 16'h0000, 0, "post_bp");

    // Reset during the scan discards the pending result and reseeds the LFSR.
    drive(pack4(1, 2, 3, 4), 16'h0000, 3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_scan_out_valid", 32'(out_valid), 32'd0);
    check("rst_scan_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    model_lfsr = SEED;
    repeat (8) @(posedge clk);
    #1;
    check("rst_scan_discarded", 32'(out_valid), 32'd0);
    drive(pack4(1*256, 5*256, 2*256, 3*256), 16'h0100, 1);
    wait_out(lat);
    check("reseed_explored", 32'(explored), 32'd1);
    check("reseed_idx", 32'(action_idx), 32'd0);
    check_out("reseed");
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
